// File: rtl/frame_sync_pkg.sv
// rtl/frame_sync_pkg.sv - shared constants and types for the framed 10-bit sync link
package frame_sync_pkg;

    localparam int FRAME_LEN = 16;

    localparam logic [1:0] TAG_SYNC = 2'b10;
    localparam logic [1:0] TAG_DATA = 2'b01;
    localparam logic [9:0] IDLE_SYM = 10'h000;

    localparam logic [9:0] DEFAULT_SYNC_CODE = {TAG_SYNC, 8'hA5};

    typedef enum logic {
        ST_HUNT    = 1'b0,
        ST_COLLECT = 1'b1
    } frame_state_t;

    typedef enum logic [1:0] {
        SYM_IDLE    = 2'd0,
        SYM_SYNC    = 2'd1,
        SYM_DATA    = 2'd2,
        SYM_INVALID = 2'd3
    } sym_class_t;

endpackage

// File: rtl/frame_sym_classify.sv
// rtl/frame_sym_classify.sv - combinational decode of a line symbol into its class
module frame_sym_classify
    import frame_sync_pkg::*;
#(
    parameter logic [9:0] SYNC_CODE = DEFAULT_SYNC_CODE
) (
    input  logic [9:0]  i_sym,
    output sym_class_t  o_class
);

    // Exact sync match wins over the tag decode, so a custom SYNC_CODE carrying the DATA tag still frames.
    always_comb begin
        o_class = SYM_INVALID;
        if (i_sym == SYNC_CODE) begin
            o_class = SYM_SYNC;
        end else if (i_sym == IDLE_SYM) begin
            o_class = SYM_IDLE;
        end else if (i_sym[9:8] == TAG_DATA) begin
            o_class = SYM_DATA;
        end
    end

endmodule

// File: rtl/frame_receiver_with_sync.sv
// rtl/frame_receiver_with_sync.sv - sync hunt, 16-byte frame capture and lock tracking
module frame_receiver_with_sync
    import frame_sync_pkg::*;
#(
    parameter logic [9:0] SYNC_CODE   = DEFAULT_SYNC_CODE,
    parameter int         LOCK_FRAMES = 2,
    parameter int         LOSS_FRAMES = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sym_valid,
    input  logic [9:0]  frame_data_with_sync,
    output logic [7:0]  frame_data_out0,
    output logic [7:0]  frame_data_out1,
    output logic [7:0]  frame_data_out2,
    output logic [7:0]  frame_data_out3,
    output logic [7:0]  frame_data_out4,
    output logic [7:0]  frame_data_out5,
    output logic [7:0]  frame_data_out6,
    output logic [7:0]  frame_data_out7,
    output logic [7:0]  frame_data_out8,
    output logic [7:0]  frame_data_out9,
    output logic [7:0]  frame_data_out10,
    output logic [7:0]  frame_data_out11,
    output logic [7:0]  frame_data_out12,
    output logic [7:0]  frame_data_out13,
    output logic [7:0]  frame_data_out14,
    output logic [7:0]  frame_data_out15,
    output logic        frame_valid,
    output logic        locked,
    output logic        sync_err
);

    localparam logic [3:0] LOCK_N   = LOCK_FRAMES[3:0];
    localparam logic [3:0] LOSS_N   = LOSS_FRAMES[3:0];
    localparam logic [3:0] LAST_IDX = 4'(FRAME_LEN - 1);

    frame_state_t r_state, w_state_nxt;
    logic [3:0]   r_idx, w_idx_nxt;
    logic [3:0]   r_good_cnt, w_good_nxt;
    logic [3:0]   r_bad_cnt, w_bad_nxt;
    logic [3:0]   w_bad_inc;
    logic         r_locked, w_locked_nxt;
    logic         r_frame_valid, r_sync_err;
    logic         w_frame_err, w_frame_good, w_store, w_report;
    logic [7:0]   w_byte;
    sym_class_t   w_class;

    // The final byte is taken straight from the line, so only 15 bytes need buffering.
    logic [7:0]   r_buf [0:FRAME_LEN-2];
    logic [7:0]   r_out [0:FRAME_LEN-1];

    assign w_byte = frame_data_with_sync[7:0];

    frame_sym_classify #(
        .SYNC_CODE (SYNC_CODE)
    ) u_classify (
        .i_sym   (frame_data_with_sync),
        .o_class (w_class)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_idx_nxt    = r_idx;
        w_frame_err  = 1'b0;
        w_frame_good = 1'b0;
        w_store      = 1'b0;
        if (sym_valid) begin
            case (r_state)
                ST_HUNT: begin
                    case (w_class)
                        SYM_SYNC: begin
                            w_state_nxt = ST_COLLECT;
                            w_idx_nxt   = 4'd0;
                        end
                        SYM_DATA:    w_frame_err = r_locked;
                        SYM_INVALID: w_frame_err = 1'b1;
                        default:     ;
                    endcase
                end
                ST_COLLECT: begin
                    case (w_class)
                        SYM_DATA: begin
                            w_store = 1'b1;
                            if (r_idx == LAST_IDX) begin
                                w_frame_good = 1'b1;
                                w_state_nxt  = ST_HUNT;
                                w_idx_nxt    = 4'd0;
                            end else begin
                                w_idx_nxt = r_idx + 4'd1;
                            end
                        end
                        SYM_SYNC: begin
                            w_frame_err = 1'b1;
                            w_idx_nxt   = 4'd0;
                        end
                        SYM_INVALID: begin
                            w_frame_err = 1'b1;
                            w_state_nxt = ST_HUNT;
                            w_idx_nxt   = 4'd0;
                        end
                        default: ;
                    endcase
                end
                default: w_state_nxt = ST_HUNT;
            endcase
        end
    end

    // Lock bookkeeping is resolved in the same cycle so locked and the report decision agree.
    always_comb begin
        w_good_nxt   = r_good_cnt;
        w_bad_nxt    = r_bad_cnt;
        w_locked_nxt = r_locked;
        w_bad_inc    = (r_bad_cnt == 4'hF) ? r_bad_cnt : r_bad_cnt + 4'd1;
        if (w_frame_err) begin
            w_good_nxt = 4'd0;
            if (r_locked) begin
                if (w_bad_inc >= LOSS_N) begin
                    w_locked_nxt = 1'b0;
                    w_bad_nxt    = 4'd0;
                end else begin
                    w_bad_nxt = w_bad_inc;
                end
            end
        end else if (w_frame_good) begin
            w_bad_nxt  = 4'd0;
            w_good_nxt = (r_good_cnt >= LOCK_N) ? LOCK_N : r_good_cnt + 4'd1;
            if (w_good_nxt >= LOCK_N) begin
                w_locked_nxt = 1'b1;
            end
        end
        w_report = w_frame_good && w_locked_nxt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_HUNT;
            r_idx         <= 4'd0;
            r_good_cnt    <= 4'd0;
            r_bad_cnt     <= 4'd0;
            r_locked      <= 1'b0;
            r_frame_valid <= 1'b0;
            r_sync_err    <= 1'b0;
            for (int i = 0; i < FRAME_LEN; i++) begin
                r_out[i] <= 8'h00;
            end
        end else begin
            r_state       <= w_state_nxt;
            r_idx         <= w_idx_nxt;
            r_good_cnt    <= w_good_nxt;
            r_bad_cnt     <= w_bad_nxt;
            r_locked      <= w_locked_nxt;
            r_frame_valid <= w_report;
            r_sync_err    <= w_frame_err;
            if (w_report) begin
                for (int i = 0; i < FRAME_LEN - 1; i++) begin
                    r_out[i] <= r_buf[i];
                end
                r_out[FRAME_LEN-1] <= w_byte;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_store && (r_idx != LAST_IDX)) begin
            r_buf[r_idx] <= w_byte;
        end
    end

    assign frame_valid      = r_frame_valid;
    assign locked           = r_locked;
    assign sync_err         = r_sync_err;
    assign frame_data_out0  = r_out[0];
    assign frame_data_out1  = r_out[1];
    assign frame_data_out2  = r_out[2];
    assign frame_data_out3  = r_out[3];
    assign frame_data_out4  = r_out[4];
    assign frame_data_out5  = r_out[5];
    assign frame_data_out6  = r_out[6];
    assign frame_data_out7  = r_out[7];
    assign frame_data_out8  = r_out[8];
    assign frame_data_out9  = r_out[9];
    assign frame_data_out10 = r_out[10];
    assign frame_data_out11 = r_out[11];
    assign frame_data_out12 = r_out[12];
    assign frame_data_out13 = r_out[13];
    assign frame_data_out14 = r_out[14];
    assign frame_data_out15 = r_out[15];

endmodule

// File: tb/tb_frame_receiver_with_sync.sv
// tb/tb_frame_receiver_with_sync.sv - randomized scoreboard bench for frame_receiver_with_sync
module tb_frame_receiver_with_sync;

    localparam int         LOCK = 2;
    localparam int         LOSS = 3;
    localparam logic [9:0] SYNC = 10'h2A5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       sym_valid = 1'b0;
    logic [9:0] sym = 10'h000;
    logic [7:0] dout [0:15];
    logic       fv, lk, serr;

    int checks = 0;
    int errors = 0;

    frame_receiver_with_sync #(
        .SYNC_CODE   (SYNC),
        .LOCK_FRAMES (LOCK),
        .LOSS_FRAMES (LOSS)
    ) dut (
        .clk                  (clk),
        .reset                (rst_n),
        .sym_valid            (sym_valid),
        .frame_data_with_sync (sym),
        .frame_data_out0      (dout[0]),
        .frame_data_out1      (dout[1]),
        .frame_data_out2      (dout[2]),
        .frame_data_out3      (dout[3]),
        .frame_data_out4      (dout[4]),
        .frame_data_out5      (dout[5]),
        .frame_data_out6      (dout[6]),
        .frame_data_out7      (dout[7]),
        .frame_data_out8      (dout[8]),
        .frame_data_out9      (dout[9]),
        .frame_data_out10     (dout[10]),
        .frame_data_out11     (dout[11]),
        .frame_data_out12     (dout[12]),
        .frame_data_out13     (dout[13]),
        .frame_data_out14     (dout[14]),
        .frame_data_out15     (dout[15]),
        .frame_valid          (fv),
        .locked               (lk),
        .sync_err             (serr)
    );

    always #5 clk = ~clk;

    // Reference model: frame-level view using a byte queue and plain lock counters.
    logic [127:0] exp_frames [$];
    int           exp_errs [$];
    bit           m_collect = 1'b0;
    logic [7:0]   m_bytes [$];
    int           m_good = 0;
    int           m_bad = 0;
    bit           m_locked = 1'b0;
    int           sym_no = 0;

    function automatic logic [127:0] cur_out();
        logic [127:0] v;
        for (int i = 0; i < 16; i++) v[8*i +: 8] = dout[i];
        return v;
    endfunction

    task automatic model_reset();
        m_collect = 1'b0;
        m_bytes.delete();
        m_good = 0;
        m_bad = 0;
        m_locked = 1'b0;
        exp_frames.delete();
        exp_errs.delete();
    endtask

    task automatic model(input logic [9:0] s);
        bit err, good, is_sync, is_data, is_idle;
        logic [127:0] p;
        err = 1'b0;
        good = 1'b0;
        is_sync = (s == SYNC);
        is_idle = (s == 10'h000);
        is_data = !is_sync && !is_idle && (s[9:8] == 2'b01);
        sym_no++;
        if (!m_collect) begin
            if (is_sync) begin
                m_collect = 1'b1;
                m_bytes.delete();
            end else if (is_data) begin
                err = m_locked;
            end else if (!is_idle) begin
                err = 1'b1;
            end
        end else begin
            if (is_data) begin
                m_bytes.push_back(s[7:0]);
                if (m_bytes.size() == 16) begin
                    good = 1'b1;
                    m_collect = 1'b0;
                end
            end else if (is_sync) begin
                err = 1'b1;
                m_bytes.delete();
            end else if (!is_idle) begin
                err = 1'b1;
                m_collect = 1'b0;
            end
        end
        if (err) begin
            exp_errs.push_back(sym_no);
            m_good = 0;
            if (m_locked) begin
                m_bad++;
                if (m_bad >= LOSS) begin
                    m_locked = 1'b0;
                    m_bad = 0;
                end
            end
        end
        if (good) begin
            m_bad = 0;
            if (m_good < LOCK) m_good++;
            if (m_good >= LOCK) m_locked = 1'b1;
            if (m_locked) begin
                for (int i = 0; i < 16; i++) p[8*i +: 8] = m_bytes[i];
                exp_frames.push_back(p);
            end
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT pulses, and checks held state every cycle.
    bit           mon_en = 1'b0;
    logic [127:0] last_seen = '0;
    logic [127:0] mon_got, mon_exp;
    int           mon_tag;

    always @(negedge clk) begin
        if (mon_en) begin
            if (!rst_n) last_seen = '0;
            mon_got = cur_out();
            checks++;
            if (fv !== (exp_frames.size() > 0)) begin
                errors++;
                $display("FAIL frame_valid got=%0b want=%0b t=%0t", fv, exp_frames.size() > 0, $time);
            end
            if (exp_frames.size() > 0) begin
                mon_exp = exp_frames.pop_front();
                if (fv) last_seen = mon_exp;
            end
            checks++;
            if (mon_got !== last_seen) begin
                errors++;
                $display("FAIL frame_data got=%h want=%h t=%0t", mon_got, last_seen, $time);
            end
            checks++;
            if (serr !== (exp_errs.size() > 0)) begin
                errors++;
                $display("FAIL sync_err got=%0b want=%0b t=%0t", serr, exp_errs.size() > 0, $time);
            end
            if (exp_errs.size() > 0) mon_tag = exp_errs.pop_front();
            checks++;
            if (lk !== m_locked) begin
                errors++;
                $display("FAIL locked got=%0b want=%0b t=%0t", lk, m_locked, $time);
            end
        end
    end

    task automatic send_sym(input logic [9:0] s, input int gap);
        repeat (gap) begin
            @(negedge clk); #2;
            sym_valid = 1'b0;
            sym = 10'($urandom);
        end
        @(negedge clk); #2;
        sym_valid = 1'b1;
        sym = s;
        model(s);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(negedge clk); #2;
            sym_valid = 1'b0;
            sym = 10'($urandom);
        end
    endtask

    task automatic send_frame(input logic [127:0] p, input int idle_a, input int idle_b, input bit gaps);
        send_sym(SYNC, 0);
        for (int i = 0; i < 16; i++) begin
            send_sym({2'b01, p[8*i +: 8]}, gaps ? 1 : 0);
            if (i == idle_a || i == idle_b) send_sym(10'h000, 0);
        end
    endtask

    task automatic do_reset();
        @(negedge clk); #2;
        sym_valid = 1'b0;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (cur_out() !== '0 || fv !== 1'b0 || lk !== 1'b0 || serr !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got=%h/%b%b%b want=0", cur_out(), fv, lk, serr);
        end
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    function automatic logic [9:0] rand_invalid();
        logic [9:0] s;
        s = 10'h3FF;
        for (int k = 0; k < 50; k++) begin
            s = 10'($urandom);
            if (s != SYNC && s != 10'h000 && s[9:8] != 2'b01) return s;
        end
        return 10'h3FF;
    endfunction

    function automatic logic [127:0] rand_payload();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    logic [127:0] p0;
    logic [7:0]   plan_bytes [16];

    initial begin
        plan_bytes = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF, 8'h01, 8'h02,
                       8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A};
        for (int i = 0; i < 16; i++) p0[8*i +: 8] = plan_bytes[i];

        #1 rst_n = 1'b0;
        #3;
        checks++;
        if (cur_out() !== '0 || fv !== 1'b0 || lk !== 1'b0 || serr !== 1'b0) begin
            errors++;
            $display("FAIL initial_reset got=%h/%b%b%b want=0", cur_out(), fv, lk, serr);
        end
        mon_en = 1'b1;
        @(negedge clk); #2;
        rst_n = 1'b1;

        // Two frames to lock, the second is reported.
        send_frame(p0, -1, -1, 1'b0);
        send_frame(p0, -1, -1, 1'b0);
        idle_cycles(3);
        checks++;
        if (dout[0] !== 8'hAA || dout[5] !== 8'hFF || dout[15] !== 8'h0A || lk !== 1'b1) begin
            errors++;
            $display("FAIL plan_frame2 got=%h,%h,%h lk=%b want=aa,ff,0a lk=1", dout[0], dout[5], dout[15], lk);
        end

        send_frame(p0, 2, 8, 1'b0);

        // Short frame cut by an early sync, then a full frame.
        send_sym(SYNC, 0);
        for (int i = 0; i < 8; i++) send_sym({2'b01, 8'($urandom)}, 0);
        send_frame(rand_payload(), -1, -1, 1'b0);

        // Three invalid symbols drop lock.
        repeat (3) send_sym(10'h3FF, 0);
        idle_cycles(2);
        checks++;
        if (lk !== 1'b0) begin
            errors++;
            $display("FAIL plan_lock_loss got=%b want=0", lk);
        end
        send_frame(rand_payload(), -1, -1, 1'b0);
        send_frame(rand_payload(), -1, -1, 1'b0);

        send_frame(rand_payload(), -1, -1, 1'b1);

        // Reset mid-frame discards both the partial frame and the lock progress.
        do_reset();
        send_frame(rand_payload(), -1, -1, 1'b0);
        send_sym(SYNC, 0);
        for (int i = 0; i < 7; i++) send_sym({2'b01, 8'($urandom)}, 0);
        do_reset();
        send_frame(rand_payload(), -1, -1, 1'b0);
        send_frame(rand_payload(), -1, -1, 1'b0);

        for (int n = 0; n < 250; n++) begin
            int c;
            c = $urandom_range(0, 9);
            if (c <= 4) begin
                send_frame(rand_payload(), $urandom_range(0, 20) - 1, $urandom_range(0, 20) - 1,
                           1'($urandom_range(0, 3) == 0));
            end else if (c == 5) begin
                int k;
                k = $urandom_range(0, 14);
                send_sym(SYNC, 0);
                for (int i = 0; i < k; i++) send_sym({2'b01, 8'($urandom)}, 0);
            end else if (c == 6) begin
                send_sym(rand_invalid(), 0);
            end else if (c == 7) begin
                send_sym({2'b01, 8'($urandom)}, 0);
            end else if (c == 8) begin
                send_sym(10'h000, 0);
            end else begin
                if ($urandom_range(0, 4) == 0) do_reset();
                else idle_cycles($urandom_range(1, 3));
            end
        end

        idle_cycles(5);
        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
